booth_mult_seq: RTL

Iterative radix-4 Booth multiplier, the parametrised sequential successor to the team's combinational 16x16 Booth/CSA multiplier.
- Retires one Booth digit per clock through a single adder, trading latency for area.
- Supports signed or unsigned operands, selected per transaction.
- Uses valid/ready handshakes on both input and output, so it drops into pipelined datapaths with backpressure.

---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_r4_digit.sv | 30 +++
 rtl/booth_mult_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
//   state_t        : sequencer states of booth_mult_seq
//   booth_digit_t  : decoded radix-4 Booth digit {neg, two, zero}
//   digit_count()  : number of Booth digits retired for a given operand width
//   booth_encode() : 3-bit multiplier window -> decoded digit
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  // Operands are extended by two bits, so one extra digit covers the sign/zero extension.
  function automatic int unsigned digit_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Window is {y[2i+1], y[2i], y[2i-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] win);
    booth_digit_t d;
    d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
    unique case (win)
      3'b000, 3'b111: d.zero = 1'b1;
      3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
      3'b011:         d.two  = 1'b1;
      3'b100:         d = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
      3'b101, 3'b110: d.neg  = 1'b1;
      default:        d.zero = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth partial-product generator.
//   win_i : multiplier window {y[2i+1], y[2i], y[2i-1]}
//   x_i   : multiplicand, already extended to WIDTH+2 bits
//   pp_o  : signed partial product digit * x, WIDTH+3 bits (holds +-2x)
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       win_i,
  input  logic [WIDTH+1:0] x_i,
  output logic [WIDTH+2:0] pp_o
);

  booth_digit_t     dig;
  logic [WIDTH+2:0] mag;

  always_comb begin
    dig = booth_encode(win_i);
    if (dig.zero) begin
      mag = '0;
    end else if (dig.two) begin
      mag = {x_i, 1'b0};
    end else begin
      mag = {x_i[WIDTH+1], x_i};
    end
    pp_o = dig.neg ? -mag : mag;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock through a single adder.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_x, in_y, in_signed sampled on accept)
//   out_valid/out_ready : product handshake, out_z = 2*WIDTH-bit product
//   busy                : high while digits are being retired
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic               busy
);

  localparam int unsigned N    = digit_count(WIDTH);
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned AccW = 2 * WIDTH + 4;

  state_t               state_q, state_d;
  logic [WIDTH+1:0]     x_q, x_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic                 prev_q, prev_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic                 accept;
  logic [WIDTH+1:0]     x_ext, y_ext;
  logic [WIDTH+2:0]     pp;
  logic [WIDTH+3:0]     sum;

  assign accept = in_valid & in_ready;
  assign x_ext  = {{2{in_signed & in_x[WIDTH-1]}}, in_x};
  assign y_ext  = {{2{in_signed & in_y[WIDTH-1]}}, in_y};

  // The multiplier lives in the low half of the accumulator and is consumed two bits per step
  // while product bits shift in from above.
  booth_r4_digit #(
    .WIDTH(WIDTH)
  ) u_digit (
    .win_i({acc_q[1:0], prev_q}),
    .x_i  (x_q),
    .pp_o (pp)
  );

  // Upper half after each shift stays below 2^WIDTH in magnitude, so WIDTH+2 bits hold it;
  // the sum itself needs WIDTH+4 before the shift.
  assign sum = {{2{acc_q[AccW-1]}}, acc_q[AccW-1 -: WIDTH+2]} + {pp[WIDTH+2], pp};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun);
    out_z     = z_q;
  end

  // Datapath next state
  always_comb begin
    x_d    = x_q;
    acc_d  = acc_q;
    prev_d = prev_q;
    cnt_d  = cnt_q;
    z_d    = z_q;
    if (accept) begin
      x_d    = x_ext;
      acc_d  = {{(WIDTH + 2){1'b0}}, y_ext};
      prev_d = 1'b0;
      cnt_d  = CntW'(N);
    end else if (state_q == StRun) begin
      if (cnt_q != '0) begin
        acc_d  = {sum, acc_q[WIDTH+1:2]};
        prev_d = acc_q[1];
        cnt_d  = cnt_q - CntW'(1);
      end else begin
        z_d = acc_q[2*WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      acc_q  <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      z_q    <= '0;
    end else begin
      x_q    <= x_d;
      acc_q  <= acc_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

endmodule
